// File: rtl/commit_mon_pkg.sv
// Shared types and helpers for the retire-stream commit monitor.
package commit_mon_pkg;

   localparam int unsigned PC_W = 32;

   typedef enum logic [1:0] {
      ST_RUN       = 2'd0,
      ST_HALTED    = 2'd1,
      ST_TIMED_OUT = 2'd2
   } mon_state_e;

   // A retiring taken branch/jump whose target is itself: the program spins forever.
   function automatic logic is_self_loop(input logic            valid,
                                         input logic            br,
                                         input logic [PC_W-1:0] pc,
                                         input logic [PC_W-1:0] pc_next);
      return valid & br & (pc == pc_next);
   endfunction

endpackage

// File: rtl/commit_prefix.sv
// Qualifies retire channels up to and including the first self-loop and
// produces each channel's offset (qualified channels below it).
module commit_prefix #(
   parameter int unsigned NUM_CH = 2
) (
   input  logic [NUM_CH-1:0]                       valid,
   input  logic [NUM_CH-1:0]                       self_loop,
   input  logic                                    enable,
   output logic [NUM_CH-1:0]                       qual,
   output logic [NUM_CH*$clog2(NUM_CH+1)-1:0]      offset,
   output logic [$clog2(NUM_CH+1)-1:0]             count,
   output logic                                    loop_hit
);

   localparam int unsigned CNT_W = $clog2(NUM_CH + 1);

   logic [CNT_W-1:0] run_cnt;
   logic             blocked;

   // Walk channels low to high; a qualified self-loop masks everything above it.
   always_comb begin
      qual     = '0;
      offset   = '0;
      run_cnt  = '0;
      blocked  = 1'b0;
      loop_hit = 1'b0;
      for (int i = 0; i < int'(NUM_CH); i++) begin
         offset[i*CNT_W +: CNT_W] = run_cnt;
         if (enable && valid[i] && !blocked) begin
            qual[i] = 1'b1;
            run_cnt = run_cnt + CNT_W'(1);
            if (self_loop[i]) begin
               blocked  = 1'b1;
               loop_hit = 1'b1;
            end
         end
      end
      count = run_cnt;
   end

endmodule

// File: rtl/commit_monitor.sv
// Commit monitor: numbers retiring instructions, detects self-loops (halt),
// idle timeouts and non-contiguous retire valid patterns.
module commit_monitor
   import commit_mon_pkg::*;
#(
   parameter int unsigned NUM_CH  = 2,
   parameter int unsigned ORDER_W = 64,
   parameter int unsigned TIMEOUT = 1000
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_CH-1:0]         commit_valid,
   input  logic [NUM_CH*PC_W-1:0]    commit_pc,
   input  logic [NUM_CH*PC_W-1:0]    commit_pc_next,
   input  logic [NUM_CH-1:0]         commit_br,
   output logic [NUM_CH*ORDER_W-1:0] order,
   output logic [NUM_CH-1:0]         commit_out,
   output logic                      halt,
   output logic                      timeout,
   output logic                      gap_err,
   output logic [ORDER_W-1:0]        retired
);

   localparam int unsigned CNT_W  = $clog2(NUM_CH + 1);
   localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);

   mon_state_e          state_q, state_d;
   logic [ORDER_W-1:0]  retired_q, retired_d;
   logic [IDLE_W-1:0]   idle_q, idle_d;
   logic                halt_q, halt_d;
   logic                timeout_q, timeout_d;
   logic                gap_q, gap_d;

   logic [NUM_CH-1:0]       self_loop;
   logic [NUM_CH-1:0]       qual;
   logic [NUM_CH*CNT_W-1:0] offset;
   logic [CNT_W-1:0]        count;
   logic                    loop_hit;
   logic                    enable;
   logic                    seen_zero;
   logic                    gap_c;

   // Per-channel self-loop predicate.
   always_comb begin
      self_loop = '0;
      for (int i = 0; i < int'(NUM_CH); i++) begin
         self_loop[i] = is_self_loop(commit_valid[i], commit_br[i],
                                     commit_pc[i*PC_W +: PC_W],
                                     commit_pc_next[i*PC_W +: PC_W]);
      end
   end

   // Gap detection: any clear valid bit below a set one.
   always_comb begin
      seen_zero = 1'b0;
      gap_c     = 1'b0;
      for (int i = 0; i < int'(NUM_CH); i++) begin
         if (!commit_valid[i]) begin
            seen_zero = 1'b1;
         end else if (seen_zero) begin
            gap_c = 1'b1;
         end
      end
   end

   // Commits are only qualified while running and out of reset.
   assign enable = rst & (state_q == ST_RUN);

   commit_prefix #(
      .NUM_CH (NUM_CH)
   ) u_prefix (
      .valid     (commit_valid),
      .self_loop (self_loop),
      .enable    (enable),
      .qual      (qual),
      .offset    (offset),
      .count     (count),
      .loop_hit  (loop_hit)
   );

   // Combinational per-channel order numbers.
   always_comb begin
      order = '0;
      for (int i = 0; i < int'(NUM_CH); i++) begin
         order[i*ORDER_W +: ORDER_W] = retired_q + ORDER_W'(offset[i*CNT_W +: CNT_W]);
      end
   end

   assign commit_out = qual;

   // Next-state: counting, halt on self-loop, timeout on sustained idleness.
   always_comb begin
      state_d   = state_q;
      retired_d = retired_q;
      idle_d    = idle_q;
      halt_d    = halt_q;
      timeout_d = timeout_q;
      gap_d     = gap_q | gap_c;
      case (state_q)
         ST_RUN: begin
            retired_d = retired_q + ORDER_W'(count);
            if (loop_hit) begin
               state_d = ST_HALTED;
               halt_d  = 1'b1;
               idle_d  = '0;
            end else if (count != '0) begin
               idle_d = '0;
            end else if (idle_q >= IDLE_W'(TIMEOUT - 1)) begin
               state_d   = ST_TIMED_OUT;
               timeout_d = 1'b1;
               idle_d    = IDLE_W'(TIMEOUT);
            end else begin
               idle_d = idle_q + IDLE_W'(1);
            end
         end
         ST_HALTED, ST_TIMED_OUT: begin
            state_d = state_q;
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

   // State and counter registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_RUN;
         retired_q <= '0;
         idle_q    <= '0;
         halt_q    <= 1'b0;
         timeout_q <= 1'b0;
         gap_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         retired_q <= retired_d;
         idle_q    <= idle_d;
         halt_q    <= halt_d;
         timeout_q <= timeout_d;
         gap_q     <= gap_d;
      end
   end

   assign halt    = halt_q;
   assign timeout = timeout_q;
   assign gap_err = gap_q;
   assign retired = retired_q;

endmodule

// File: tb/tb_commit_monitor.sv
// Directed and randomized checks of commit_monitor against a behavioural model.
module tb_commit_monitor;

   localparam int NUM_CH  = 2;
   localparam int ORDER_W = 5;
   localparam int TIMEOUT = 4;
   localparam int MODV    = 1 << ORDER_W;

   logic                      clk;
   logic                      rst;
   logic [NUM_CH-1:0]         commit_valid;
   logic [NUM_CH*32-1:0]      commit_pc;
   logic [NUM_CH*32-1:0]      commit_pc_next;
   logic [NUM_CH-1:0]         commit_br;
   logic [NUM_CH*ORDER_W-1:0] order;
   logic [NUM_CH-1:0]         commit_out;
   logic                      halt;
   logic                      timeout;
   logic                      gap_err;
   logic [ORDER_W-1:0]        retired;

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model state.
   int m_retired;
   int m_idle;
   bit m_halt;
   bit m_to;
   bit m_gap;

   commit_monitor #(
      .NUM_CH  (NUM_CH),
      .ORDER_W (ORDER_W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .commit_valid   (commit_valid),
      .commit_pc      (commit_pc),
      .commit_pc_next (commit_pc_next),
      .commit_br      (commit_br),
      .order          (order),
      .commit_out     (commit_out),
      .halt           (halt),
      .timeout        (timeout),
      .gap_err        (gap_err),
      .retired        (retired)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_retired = 0;
      m_idle    = 0;
      m_halt    = 0;
      m_to      = 0;
      m_gap     = 0;
   endtask

   task automatic check_regs(input string tag);
      check({tag, ".retired"}, 64'(retired), 64'(m_retired));
      check({tag, ".halt"},    64'(halt),    64'(m_halt));
      check({tag, ".timeout"}, 64'(timeout), 64'(m_to));
      check({tag, ".gap_err"}, 64'(gap_err), 64'(m_gap));
   endtask

   // Assert reset between edges, check immediate clear, release just after an edge.
   task automatic apply_reset();
      @(negedge clk);
      rst            = 1'b0;
      commit_valid   = '0;
      commit_br      = '0;
      commit_pc      = '0;
      commit_pc_next = '0;
      #1;
      model_reset();
      check_regs("reset");
      check("reset.commit_out", 64'(commit_out), 64'd0);
      check("reset.order", 64'(order), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   // One clock: drive, check combinational outputs, clock, check registers.
   task automatic cycle(input logic [1:0] v, input logic [1:0] br,
                        input logic [31:0] pc0, input logic [31:0] pcn0,
                        input logic [31:0] pc1, input logic [31:0] pcn1);
      logic [31:0] pc  [2];
      logic [31:0] pcn [2];
      logic [1:0]  q;
      int          ord [2];
      int          q_cnt;
      bit          loop;
      bit          stop;
      bit          zero_seen;
      pc[0] = pc0; pc[1] = pc1; pcn[0] = pcn0; pcn[1] = pcn1;
      @(negedge clk);
      commit_valid   = v;
      commit_br      = br;
      commit_pc      = {pc1, pc0};
      commit_pc_next = {pcn1, pcn0};
      #1;
      q     = '0;
      q_cnt = 0;
      loop  = 0;
      stop  = m_halt || m_to;
      for (int i = 0; i < NUM_CH; i++) begin
         ord[i] = (m_retired + q_cnt) % MODV;
         if (!stop && v[i]) begin
            q[i] = 1'b1;
            q_cnt++;
            if (br[i] && pc[i] == pcn[i]) begin
               loop = 1;
               stop = 1;
            end
         end
      end
      check("commit_out", 64'(commit_out), 64'(q));
      check("order0", 64'(order[ORDER_W-1:0]), 64'(ord[0]));
      check("order1", 64'(order[2*ORDER_W-1:ORDER_W]), 64'(ord[1]));
      @(posedge clk);
      #1;
      zero_seen = 0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (!v[i]) zero_seen = 1;
         else if (zero_seen) m_gap = 1;
      end
      m_retired = (m_retired + q_cnt) % MODV;
      if (!m_halt && !m_to) begin
         if (loop) begin
            m_halt = 1;
         end else if (q_cnt > 0) begin
            m_idle = 0;
         end else begin
            m_idle++;
            if (m_idle >= TIMEOUT) m_to = 1;
         end
      end
      check_regs("cycle");
   endtask

   initial begin
      rst            = 1'b1;
      commit_valid   = '0;
      commit_br      = '0;
      commit_pc      = '0;
      commit_pc_next = '0;
      model_reset();

      // Three full-width cycles: orders (0,1),(2,3),(4,5).
      apply_reset();
      for (int k = 0; k < 3; k++)
         cycle(2'b11, 2'b00, 32'h100 + 32'(8*k), 32'h104 + 32'(8*k),
               32'h104 + 32'(8*k), 32'h108 + 32'(8*k));
      check("d1.retired6", 64'(retired), 64'd6);

      // Single commit then a self-loop on ch0.
      apply_reset();
      cycle(2'b01, 2'b00, 32'h40, 32'h44, 32'h0, 32'h0);
      cycle(2'b01, 2'b01, 32'h60, 32'h60, 32'h0, 32'h0);
      check("d2.halt", 64'(halt), 64'd1);
      cycle(2'b11, 2'b00, 32'h64, 32'h68, 32'h68, 32'h6c);
      check("d2.frozen", 64'(retired), 64'd2);

      // Self-loop on ch0 masks ch1.
      apply_reset();
      cycle(2'b11, 2'b01, 32'h80, 32'h80, 32'h84, 32'h88);
      check("d3.retired", 64'(retired), 64'd1);
      check("d3.halt", 64'(halt), 64'd1);

      // Idle timeout after exactly TIMEOUT edges.
      apply_reset();
      for (int k = 0; k < 3; k++) cycle(2'b00, 2'b00, 0, 0, 0, 0);
      check("d4.no_timeout_yet", 64'(timeout), 64'd0);
      cycle(2'b00, 2'b00, 0, 0, 0, 0);
      check("d4.timeout", 64'(timeout), 64'd1);
      check("d4.no_halt", 64'(halt), 64'd0);

      // Gap pattern.
      apply_reset();
      cycle(2'b10, 2'b00, 32'h0, 32'h0, 32'h200, 32'h204);
      check("d5.gap", 64'(gap_err), 64'd1);

      // Counter wrap, then asynchronous reset mid-cycle.
      apply_reset();
      for (int k = 0; k < 15; k++)
         cycle(2'b11, 2'b00, 32'h300, 32'h304, 32'h304, 32'h308);
      cycle(2'b01, 2'b00, 32'h400, 32'h404, 32'h0, 32'h0);
      check("d6.max", 64'(retired), 64'(MODV - 1));
      cycle(2'b11, 2'b00, 32'h500, 32'h504, 32'h504, 32'h508);
      check("d6.wrapped", 64'(retired), 64'd1);
      @(negedge clk);
      commit_valid   = 2'b11;
      commit_pc      = {32'h604, 32'h600};
      commit_pc_next = {32'h608, 32'h604};
      #2;
      rst = 1'b0;
      #1;
      model_reset();
      check("d6.async.commit_out", 64'(commit_out), 64'd0);
      check("d6.async.order", 64'(order), 64'd0);
      check_regs("d6.async");
      @(posedge clk);
      #1;
      rst = 1'b1;
      cycle(2'b11, 2'b00, 32'h700, 32'h704, 32'h704, 32'h708);

      // Randomized episodes.
      apply_reset();
      for (int k = 0; k < 400; k++) begin
         logic [1:0]  v;
         logic [1:0]  b;
         logic [31:0] p0, p1, n0, n1;
         if ($urandom_range(0, 39) == 0 || ((m_halt || m_to) && $urandom_range(0, 5) == 0))
            apply_reset();
         v  = 2'($urandom_range(0, 3));
         b  = 2'($urandom_range(0, 3));
         p0 = $urandom & 32'hffff_fffc;
         p1 = $urandom & 32'hffff_fffc;
         n0 = ($urandom_range(0, 7) == 0) ? p0 : p0 + 32'd4;
         n1 = ($urandom_range(0, 7) == 0) ? p1 : p1 + 32'd4;
         cycle(v, b, p0, n0, p1, n1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
